fsm_enable_sequencer: RTL and testbench

//   Upstream request stage for the pulse FSM. Synchronises and debounces a raw button/trigger

---
 rtl/fsm_seq_pkg.sv | 22 ++
 rtl/fsm_enable_sequencer_debounce_edge.sv | 58 +++++
 rtl/fsm_enable_sequencer.sv | 105 ++++++++++
 tb/tb_fsm_enable_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared constants for the enable sequencer and the downstream pulse FSM.
package fsm_seq_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int GAP_CYCLES_DEF      = 4;
    localparam int PEND_W_DEF          = 3;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } issue_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fsm_enable_sequencer_debounce_edge.sv
// Synchroniser and debouncer for the raw trigger; emits a one-cycle req per accepted rise.
module debounce_edge
    import fsm_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic req_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          deb_cnt_q, deb_cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic                   req_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync_out != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = sync_out;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // req is registered one cycle behind the level change so a press reaches
    // the queue on a clean register boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            deb_cnt_q    <= '0;
            level_q      <= LOW;
            level_prev_q <= LOW;
            req_q        <= LOW;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_i};
            deb_cnt_q    <= deb_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            req_q        <= level_q & ~level_prev_q;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/fsm_enable_sequencer.sv
// Queues debounced trigger presses and issues them as spaced one-cycle enable pulses.
//   state | meaning
//   IDLE  | free to issue; fires enable as soon as pending != 0
//   GAP   | holding off so the downstream FSM returns to IDLE before the next pulse
module fsm_enable_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GAP_CYCLES      = GAP_CYCLES_DEF,
    parameter int PEND_W          = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    output logic              enable,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    localparam int GW = cnt_width(GAP_CYCLES - 2);
    localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 2);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    issue_state_e      state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              enable_q, enable_d;
    logic              ovf_q, ovf_d;
    logic              req;
    logic              issue;

    debounce_edge #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_edge (
        .clk  (clk),
        .reset(reset),
        .btn_i(btn_in),
        .req_o(req)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        enable_d = LOW;
        issue    = LOW;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    issue    = HIGH;
                    enable_d = HIGH;
                    gap_d    = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
        endcase
    end

    // A request that meets its own issue cycle cancels out, so a full queue
    // only drops when nothing leaves in the same cycle.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (req && !issue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = HIGH;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (issue && !req) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            pend_q   <= '0;
            enable_q <= LOW;
            ovf_q    <= LOW;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    assign enable   = enable_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_fsm_enable_sequencer.sv
// Bench: a default instance and a fast-debounce, slow-issue instance share one trigger.
module tb_fsm_enable_sequencer;

    localparam int S    = 2;
    localparam int PW   = 3;
    localparam int PMAX = 7;
    localparam int D_A  = 4;
    localparam int G_A  = 4;
    localparam int D_B  = 1;
    localparam int G_B  = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;
    logic en_a, en_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [PW-1:0] pend_a, pend_b;

    always #5 clk = ~clk;

    fsm_enable_sequencer dut_a (
        .clk(clk), .reset(reset), .btn_in(btn), .enable(en_a),
        .pending(pend_a), .busy(busy_a), .overflow(ovf_a)
    );

    fsm_enable_sequencer #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D_B), .GAP_CYCLES(G_B), .PEND_W(PW)
    ) dut_b (
        .clk(clk), .reset(reset), .btn_in(btn), .enable(en_b),
        .pending(pend_b), .busy(busy_b), .overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    int sh[S];
    int lvl[2], run[2], r1[2], r2[2];
    int m_pend[2], m_last[2], m_en[2], m_busy[2], m_ovf[2];

    // observation state
    int en_cnt[2], first_en[2], last_en[2], prev_en[2], ds[2], peak[2];
    int c_e, c_p, c_b, c_o, c_g;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < S; i++) sh[i] = 0;
        for (int k = 0; k < 2; k++) begin
            lvl[k] = 0; run[k] = 0; r1[k] = 0; r2[k] = 0;
            m_pend[k] = 0; m_last[k] = -1000; m_en[k] = 0; m_busy[k] = 0; m_ovf[k] = 0;
        end
    endtask

    task automatic model_step();
        int sp, dv, gv, rose, req, iss;
        sp = sh[S-1];
        for (int i = S - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = int'(btn);
        for (int k = 0; k < 2; k++) begin
            dv = (k == 0) ? D_A : D_B;
            gv = (k == 0) ? G_A : G_B;
            rose = 0;
            if (sp != lvl[k]) begin
                run[k]++;
                if (run[k] >= dv) begin
                    lvl[k] = sp;
                    run[k] = 0;
                    rose = sp;
                end
            end else begin
                run[k] = 0;
            end
            req = r2[k];
            r2[k] = r1[k];
            r1[k] = rose;
            iss = (m_pend[k] != 0 && cyc - m_last[k] >= gv) ? 1 : 0;
            m_en[k] = iss;
            if (iss != 0) m_last[k] = cyc;
            if (req != 0 && iss == 0) begin
                if (m_pend[k] == PMAX) m_ovf[k] = 1;
                else m_pend[k]++;
            end else if (iss != 0 && req == 0) begin
                m_pend[k]--;
            end
            m_busy[k] = (m_pend[k] != 0 || cyc - m_last[k] <= gv - 2) ? 1 : 0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                cyc++;
                model_step();
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            prev_en[k] = 0; last_en[k] = -1000; ds[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int k = 0; k < 2; k++) begin
                    prev_en[k] = 0; last_en[k] = -1000; ds[k] = 0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    c_e = (k == 0) ? int'(en_a) : int'(en_b);
                    c_p = (k == 0) ? int'(pend_a) : int'(pend_b);
                    c_b = (k == 0) ? int'(busy_a) : int'(busy_b);
                    c_o = (k == 0) ? int'(ovf_a) : int'(ovf_b);
                    c_g = (k == 0) ? G_A : G_B;
                    chk($sformatf("enable_%0d", k), c_e, m_en[k]);
                    chk($sformatf("pending_%0d", k), c_p, m_pend[k]);
                    chk($sformatf("busy_%0d", k), c_b, m_busy[k]);
                    chk($sformatf("overflow_%0d", k), c_o, m_ovf[k]);
                    if (c_e != 0) begin
                        chk($sformatf("no_back_to_back_%0d", k), prev_en[k], 0);
                        chk($sformatf("spacing_%0d", k), int'(cyc - last_en[k] >= c_g), 1);
                        chk($sformatf("downstream_idle_%0d", k), ds[k], 0);
                        en_cnt[k]++;
                        if (first_en[k] < 0) first_en[k] = cyc;
                        last_en[k] = cyc;
                    end
                    ds[k] = (ds[k] != 0) ? (ds[k] + 1) % 4 : ((c_e != 0) ? 1 : 0);
                    prev_en[k] = c_e;
                    if (c_p > peak[k]) peak[k] = c_p;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    task automatic clear_marks();
        for (int k = 0; k < 2; k++) begin
            en_cnt[k] = 0; first_en[k] = -1; peak[k] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_enable_a"}, int'(en_a), 0);
        chk({tag, "_pending_a"}, int'(pend_a), 0);
        chk({tag, "_busy_a"}, int'(busy_a), 0);
        chk({tag, "_overflow_a"}, int'(ovf_a), 0);
        chk({tag, "_enable_b"}, int'(en_b), 0);
        chk({tag, "_pending_b"}, int'(pend_b), 0);
        chk({tag, "_busy_b"}, int'(busy_b), 0);
        chk({tag, "_overflow_b"}, int'(ovf_b), 0);
    endtask

    task automatic press(input int n);
        for (int i = 0; i < n; i++) begin
            btn = 1'b1;
            @(negedge clk);
            btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(busy_a || busy_b), 0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0;
        clear_marks();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // clean press
        clear_marks();
        btn = 1'b1;
        t0 = cyc + 1;
        repeat (20) @(negedge clk);
        chk("t1_count_a", en_cnt[0], 1);
        chk("t1_latency_a", first_en[0] - t0, 8);
        chk("t1_count_b", en_cnt[1], 1);
        chk("t1_latency_b", first_en[1] - t0, 5);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle(200);

        // bounce, then hold
        clear_marks();
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) @(negedge clk);
        end
        btn = 1'b1;
        t0 = cyc + 1;
        repeat (20) @(negedge clk);
        chk("t2_count_a", en_cnt[0], 1);
        chk("t2_latency_a", first_en[0] - t0, 8);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle(200);

        // backlog
        clear_marks();
        press(5);
        wait_idle(400);
        chk("t3_count_b", en_cnt[1], 5);
        chk("t3_span_b", last_en[1] - first_en[1], 4 * G_B);
        chk("t3_peak_b", peak[1], 4);
        chk("t3_overflow_b", int'(ovf_b), 0);
        chk("t3_count_a", en_cnt[0], 0);

        // overflow
        clear_marks();
        press(9);
        repeat (5) @(negedge clk);
        chk("t4_saturated_b", int'(pend_b), 7);
        chk("t4_overflow_set_b", int'(ovf_b), 1);
        wait_idle(400);
        chk("t4_count_b", en_cnt[1], 8);
        chk("t4_overflow_sticky_b", int'(ovf_b), 1);
        chk("t4_drained_b", int'(pend_b), 0);

        // request coincides with issue at a full queue
        pulse_reset();
        clear_marks();
        press(8);
        repeat (5) @(negedge clk);
        chk("t5_full_b", int'(pend_b), 7);
        chk("t5_no_ovf_before_b", int'(ovf_b), 0);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_issue_b", int'(en_b), 1);
        chk("t5_pending_hold_b", int'(pend_b), 7);
        chk("t5_no_ovf_after_b", int'(ovf_b), 0);
        wait_idle(400);

        // reset in the gap with a queue, trigger still held afterwards
        pulse_reset();
        clear_marks();
        press(5);
        repeat (17) @(negedge clk);
        chk("t6_pending_b", int'(pend_b), 3);
        chk("t6_in_gap_b", int'(busy_b && !en_b), 1);
        #2 reset = 1'b1;
        btn = 1'b1;
        #1 check_zero("t6_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_marks();
        t0 = cyc + 1;
        repeat (20) @(negedge clk);
        chk("t6_count_a", en_cnt[0], 1);
        chk("t6_latency_a", first_en[0] - t0, 8);
        chk("t6_count_b", en_cnt[1], 1);
        chk("t6_latency_b", first_en[1] - t0, 5);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
